// File: rtl/mips32_run_controller.sv
// Load/run/dump sequencer for the MIPS32 pipeline core: streams a program into core memory,
// runs the core until HALT (or, with MIPS_RUN_TIMEOUT_EN defined, a cycle limit), then dumps the register file.
module mips32_run_controller #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 10,
  parameter int NREGS         = 32,
  parameter int CNT_W         = 16,
  parameter int TIMEOUT_LIMIT = 1000,
  localparam int RIDX_W       = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              core_mem_we,
  output logic [ADDR_W-1:0] core_mem_addr,
  output logic [DATA_W-1:0] core_mem_wdata,
  output logic              core_run,
  input  logic              core_halted,
  output logic [RIDX_W-1:0] core_reg_raddr,
  input  logic [DATA_W-1:0] core_reg_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [RIDX_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ADDR_W:0]   load_count,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP, S_DONE} state_t;

`ifdef MIPS_RUN_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [ADDR_W:0]   TOP_ADDR = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NREGS - 1);

  state_t           state;
  logic             prog_hs, dump_hs, tmo_hit;
  logic [CNT_W-1:0] cyc_nxt;

  assign prog_hs = prog_valid & prog_ready;
  assign dump_hs = dump_valid & dump_ready;

  assign core_mem_we    = prog_hs;
  assign core_mem_addr  = load_count[ADDR_W-1:0];
  assign core_mem_wdata = prog_ready ? prog_data : '0;

  // Register file is read combinationally, so the dump word tracks dump_idx directly.
  assign core_reg_raddr = dump_idx;
  assign dump_data      = dump_valid ? core_reg_rdata : '0;
  assign dump_last      = dump_valid & (dump_idx == LAST_IDX);

  assign cyc_nxt = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + 1'b1;
  assign tmo_hit = TMO_EN && (32'(cyc_nxt) >= TIMEOUT_LIMIT);

  always_ff @(posedge clk1) begin
    if (rst) begin
      state       <= S_IDLE;
      prog_ready  <= 1'b0;
      core_run    <= 1'b0;
      dump_valid  <= 1'b0;
      dump_idx    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      load_count  <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_LOAD;
            prog_ready  <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            load_count  <= '0;
            cycle_count <= '0;
          end
        end
        S_LOAD: begin
          if (prog_hs) begin
            load_count <= load_count + 1'b1;
            // Filling the top address ends the load even without prog_last: no wrap.
            if (prog_last || load_count == TOP_ADDR) begin
              state      <= S_RUN;
              prog_ready <= 1'b0;
              core_run   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          cycle_count <= cyc_nxt;
          if (core_halted || tmo_hit) begin
            state      <= S_DUMP;
            core_run   <= 1'b0;
            dump_valid <= 1'b1;
            dump_idx   <= '0;
            timeout    <= ~core_halted;
          end
        end
        S_DUMP: begin
          if (dump_hs) begin
            if (dump_idx == LAST_IDX) begin
              state      <= S_DONE;
              dump_valid <= 1'b0;
              dump_idx   <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              dump_idx <= dump_idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_run_controller.sv
// Scoreboard bench for mips32_run_controller: the bench plays the core (memory, regfile, HALT)
// and checks writes, dump words and end-of-run counters against a queue of expectations.
module tb_mips32_run_controller;
  localparam int DW = 32, AW = 4, NR = 32, CW = 7, TL = 100;
  localparam int RW = $clog2(NR), DEPTH = 1 << AW, CMAX = (1 << CW) - 1;

  logic clk1, rst, start, prog_valid, prog_ready, prog_last;
  logic [DW-1:0] prog_data, core_mem_wdata, core_reg_rdata, dump_data;
  logic core_mem_we, core_run, core_halted, dump_valid, dump_ready, dump_last;
  logic busy, done, timeout;
  logic [AW-1:0] core_mem_addr;
  logic [RW-1:0] core_reg_raddr, dump_idx;
  logic [AW:0] load_count;
  logic [CW-1:0] cycle_count;

  logic [DW-1:0] regs [NR];
  assign core_reg_rdata = regs[core_reg_raddr];

  mips32_run_controller #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR), .CNT_W(CW), .TIMEOUT_LIMIT(TL)) dut (
    .clk1(clk1), .rst(rst), .start(start), .prog_valid(prog_valid), .prog_ready(prog_ready),
    .prog_data(prog_data), .prog_last(prog_last), .core_mem_we(core_mem_we),
    .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata), .core_run(core_run),
    .core_halted(core_halted), .core_reg_raddr(core_reg_raddr), .core_reg_rdata(core_reg_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_last(dump_last), .busy(busy), .done(done), .timeout(timeout),
    .load_count(load_count), .cycle_count(cycle_count));

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int idx; logic [DW-1:0] data; bit last; } dw_t;
  typedef struct { int lc; int cc; bit tmo; } sum_t;
  wr_t  wq [$];
  dw_t  dq [$];
  sum_t sq [$];

  int errors = 0, checks = 0;
  int halt_at = 1000, rdy_mode = 0;

  logic [DW-1:0] prog9 [9] = '{32'h2801000a, 32'h28020014, 32'h2803001e, 32'h00222000,
                               32'h00832800, 32'h2c050000, 32'h00a62000, 32'h0c000000, 32'hfc000000};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk1); #1;
  endtask

  // Reference rules: RUN lasts until HALT is seen, or TL cycles with the timeout enabled;
  // the counter saturates at all-ones.
  function automatic int exp_cyc(input int h);
    int c = h;
`ifdef MIPS_RUN_TIMEOUT_EN
    if (h > TL) c = TL;
`endif
    if (c > CMAX) c = CMAX;
    return c;
  endfunction

  function automatic bit exp_tmo(input int h);
`ifdef MIPS_RUN_TIMEOUT_EN
    return h > TL;
`else
    return (h < 0);
`endif
  endfunction

  // Core model: raise HALT during the halt_at-th cycle that core_run is high.
  initial begin
    int run_cycles = 0;
    core_halted = 1'b0;
    forever begin
      step;
      if (core_run) begin
        run_cycles++;
        core_halted = (run_cycles == halt_at);
      end else begin
        run_cycles = 0;
        core_halted = 1'b0;
      end
    end
  end

  initial begin
    dump_ready = 1'b0;
    forever begin
      step;
      case (rdy_mode)
        0: dump_ready = 1'b1;
        1: dump_ready = ~dump_ready;
        default: dump_ready = 1'($urandom % 2);
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT presents a write, a dump handshake or done.
  initial begin
    bit stall_q = 0, done_q = 0;
    logic [RW-1:0] held_idx;
    logic [DW-1:0] held_data;
    wr_t w; dw_t d; sum_t s;
    forever begin
      @(negedge clk1);
      if (rst) begin
        stall_q = 0; done_q = 0;
      end else begin
        if (core_mem_we) begin
          if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_write: got unexpected write addr %0h required none", core_mem_addr);
          end else begin
            w = wq.pop_front();
            chk("mem_addr", core_mem_addr, w.addr);
            chk("mem_wdata", core_mem_wdata, w.data);
          end
        end
        if (stall_q) begin
          chk("hold_idx", dump_idx, held_idx);
          chk("hold_data", dump_data, held_data);
        end
        if (dump_valid) chk("core_run_in_dump", core_run, 0);
        if (dump_valid && dump_ready) begin
          if (dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL dump_word: got unexpected idx %0d required none", dump_idx);
          end else begin
            d = dq.pop_front();
            chk("dump_idx", dump_idx, d.idx);
            chk("dump_data", dump_data, d.data);
            chk("dump_last", dump_last, d.last);
          end
        end
        if (done && !done_q) begin
          if (sq.size() == 0) begin
            checks++; errors++;
            $display("FAIL done: got unexpected done required none");
          end else begin
            s = sq.pop_front();
            chk("load_count", load_count, s.lc);
            chk("cycle_count", cycle_count, s.cc);
            chk("timeout", timeout, s.tmo);
            chk("busy_at_done", busy, 0);
          end
        end
        stall_q   = dump_valid && !dump_ready;
        held_idx  = dump_idx;
        held_data = dump_data;
        done_q    = done;
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ctrl"}, {prog_ready, core_mem_we, core_run, dump_valid, dump_last, busy, done, timeout}, 0);
    chk({tag, "_counts"}, {load_count, cycle_count, core_mem_addr, dump_idx}, 0);
    chk({tag, "_data"}, {core_mem_wdata, dump_data}, 0);
  endtask

  task automatic run_seq(input int nwords, input bit use_last, input int h, input int mode,
                         input int abort_at, input bit directed);
    logic [DW-1:0] words [$];
    int nw, i, guard;
    bit hs;
    wr_t w; dw_t d; sum_t s;
    for (int k = 0; k < nwords; k++) words.push_back(directed ? prog9[k] : $urandom);
    for (int r = 0; r < NR; r++) regs[r] = $urandom;
    nw = (use_last && nwords <= DEPTH) ? nwords : DEPTH;
    for (int k = 0; k < nw; k++) begin
      w.addr = AW'(k); w.data = words[k]; wq.push_back(w);
    end
    halt_at = h;
    rdy_mode = mode;
    if (abort_at == 0) begin
      s.lc = nw; s.cc = exp_cyc(h); s.tmo = exp_tmo(h); sq.push_back(s);
      for (int r = 0; r < NR; r++) begin
        d.idx = r; d.data = regs[r]; d.last = (r == NR - 1); dq.push_back(d);
      end
    end
    start = 1'b1; step; start = 1'b0;
    i = 0; guard = 0;
    while (prog_ready && guard < 500) begin
      prog_valid = ($urandom % 4) != 0;
      prog_data  = words[i];
      prog_last  = use_last && (i == nwords - 1);
      start      = ($urandom % 8) == 0;
      @(negedge clk1);
      hs = prog_valid && prog_ready;
      step;
      if (hs) i++;
      guard++;
    end
    prog_valid = 1'b0; prog_last = 1'b0; start = 1'b0; prog_data = '0;
    if (abort_at != 0) begin
      repeat (abort_at) step;
      chk("core_run_before_abort", core_run, 1);
      rst = 1'b1; step; rst = 1'b0;
      @(negedge clk1);
      chk_reset_state("abort");
      return;
    end
    guard = 0;
    while (!done && guard < 3000) begin
      step;
      guard++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_wait: got no done after %0d cycles required done", guard);
      sq.delete(); dq.delete();
    end
    step;
  endtask

  initial begin
    int n, h;
    bit lst;
    rst = 1'b1; start = 1'b0; prog_valid = 1'b0; prog_data = '0; prog_last = 1'b0;
    for (int r = 0; r < NR; r++) regs[r] = '0;
    repeat (3) step;
    rst = 1'b0;
    @(negedge clk1);
    chk_reset_state("reset");
    repeat (3) step;
    chk("idle_without_start", {busy, prog_ready}, 0);

    run_seq(9, 1, 40, 0, 0, 1);      // sample program, HALT after 40 RUN cycles
    run_seq(9, 1, 40, 1, 0, 1);      // dump_ready toggling every cycle
    run_seq(DEPTH + 4, 0, 10, 2, 0, 0); // no prog_last: memory fills and load stops
    run_seq(DEPTH, 1, 5, 2, 0, 0);   // prog_last lands on the top address
    run_seq(1, 1, 1, 0, 0, 0);       // minimum program, HALT in first RUN cycle
    run_seq(12, 1, TL, 2, 0, 0);     // HALT exactly at the limit: HALT wins
    run_seq(6, 1, 150, 2, 0, 0);     // past the limit: timeout or saturation
    run_seq(8, 1, 1000, 0, 30, 0);   // reset mid-RUN
    run_seq(5, 1, 7, 1, 0, 0);       // reload from IDLE after the abort
    for (int t = 0; t < 6; t++) begin
      lst = ($urandom % 3) != 0;
      n = lst ? 1 + int'($urandom % 20) : DEPTH + 1 + int'($urandom % 4);
      h = 1 + int'($urandom % 140);
      run_seq(n, lst, h, int'($urandom % 3), 0, 0);
    end
    repeat (4) step;
    chk("writes_left", wq.size(), 0);
    chk("dump_left", dq.size(), 0);
    chk("summaries_left", sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
